frame_writer: RTL and testbench
===============================

FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter COL_W, default 7, meaning column index width (128 columns).
REQ-002 SHALL have parameter ROW_W, default 7, meaning row index width (128 rows).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_sof input 1 (first pixel of frame), and in_data input 16 (RGB565 {r[15:11],g[10:5],b[4:0]}).
REQ-006 SHALL have port win_x0/win_x1  input  COL_W  window column bounds, inclusive.
REQ-007 SHALL have port win_y0/win_y1  input  ROW_W  window row bounds, inclusive.
REQ-008 SHALL have port wr_stall  input  1  buffer write port unavailable this cycle.
REQ-009 SHALL have ports we output 1, waddr output COL_W+ROW_W, wdata output 12 ({r4,g4,b4}, red in [11:8]).
REQ-010 SHALL have ports frame_done output 1 and frame_abort output 1, each a one-cycle pulse.
REQ-011 SHALL have port drop_cnt  output  16  count of pixels discarded in IDLE.

Function
REQ-012 SHALL accept a pixel on a cycle with in_valid && in_ready; in_ready = !wr_stall in every state.
REQ-013 SHALL implement states IDLE and WRITE; reset enters IDLE.
REQ-014 IDLE: accepted pixel with in_sof=1 latches window bounds, writes at (win_x0,win_y0), enters WRITE; accepted pixel with in_sof=0 is dropped and drop_cnt increments, saturating at 16'hFFFF.
REQ-015 SHALL clamp a latched window with x1<x0 to x1=x0, and one with y1<y0 to y1=y0.
REQ-016 WRITE: each accepted pixel writes at the current (x,y); after a write with x==x1, x returns to x0 and y increments; otherwise x increments.
REQ-017 SHALL pulse frame_done with the write of pixel (x1,y1) and return to IDLE.
REQ-018 A pixel accepted in WRITE with in_sof=1 SHALL pulse frame_abort, relatch bounds, write at the new (x0,y0), and stay in WRITE; frame_done is not pulsed.
REQ-019 A single-pixel window (x0==x1, y0==y1) with sof SHALL write once, pulse frame_done, and remain in IDLE.
REQ-020 waddr SHALL be y*2^COL_W + x.
REQ-021 Write latency SHALL be one cycle: we, waddr, and wdata are registered and valid the cycle after acceptance; we is otherwise 0.
REQ-022 Without rounding, colour conversion SHALL truncate: r4=r5[4:1], g4=g6[5:2], b4=b5[4:1].
REQ-023 Window inputs SHALL be sampled only on an accepted sof pixel; changes at any other time are ignored.

Reset
REQ-024 With reset low at a clock edge, the block SHALL set state=IDLE, we=0, waddr=0, wdata=0, frame_done=0, frame_abort=0, drop_cnt=0, and clear latched bounds and x/y to 0.
REQ-025 Reset mid-frame SHALL abandon the frame without a frame_done or frame_abort pulse.
REQ-026 in_ready SHALL be 0 while reset is low.

Configuration
REQ-027 With macro FRAME_WRITER_ROUND_EN defined, conversion SHALL round half-up with saturation: r4=min(15,(r5+1)>>1), g4=min(15,(g6+2)>>2), b4=min(15,(b5+1)>>1).
REQ-028 With FRAME_WRITER_ROUND_EN undefined, conversion SHALL truncate per REQ-022; timing and latency are identical in both builds.

Structure
REQ-029 The shared package SHALL hold the state enum (IDLE, WRITE), the RGB565 and RGB444 field-position constants, and the 12-bit buffer word width.
REQ-030 Colour conversion SHALL be a combinational sub-module rgb565_to_444, which contains the FRAME_WRITER_ROUND_EN selection.

Verification
REQ-031 Full window 0..127 x 0..127: send 16384 pixels with sof on the first -> 16384 writes with waddr 0..16383 in order; frame_done pulses once with waddr=16383.
REQ-032 Window x 10..12, y 5..6: send 6 pixels -> waddr 650,651,652,778,779,780; frame_done pulses on the write to 780.
REQ-033 In IDLE, send 3 pixels with in_sof=0 -> no we; drop_cnt=3.
REQ-034 Send sof mid-frame after 5 pixels -> frame_abort pulses once; next waddr = new (x0,y0); no frame_done.
REQ-035 Pixel 16'hFFFF -> wdata 12'hFFF in both builds; pixel {5'd3,6'd6,5'd3} -> wdata 12'h111 when truncating, 12'h222 with FRAME_WRITER_ROUND_EN.
REQ-036 Hold wr_stall=1 for 4 cycles with in_valid=1 -> in_ready=0, no we, no pixel lost; drive reset low mid-frame -> all outputs take REQ-024 values next edge.

Source files
------------

// File: rtl/frame_writer_pkg.sv
// Shared types and constants for the frame writer: FSM states, RGB565/RGB444
// field positions and the frame-buffer word width.
package frame_writer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } fw_state_t;

  localparam int PIX_W  = 16;
  localparam int WORD_W = 12;

  // RGB565 input pixel fields
  localparam int R5_HI = 15;
  localparam int R5_LO = 11;
  localparam int G6_HI = 10;
  localparam int G6_LO = 5;
  localparam int B5_HI = 4;
  localparam int B5_LO = 0;

  // RGB444 buffer word fields
  localparam int R4_HI = 11;
  localparam int R4_LO = 8;
  localparam int G4_HI = 7;
  localparam int G4_LO = 4;
  localparam int B4_HI = 3;
  localparam int B4_LO = 0;

endpackage

// File: rtl/frame_writer_rgb565_to_444.sv
// Combinational RGB565 -> RGB444 converter. Truncates by default; defining
// FRAME_WRITER_ROUND_EN selects round-half-up with saturation at 15.
module rgb565_to_444
  import frame_writer_pkg::*;
(
  input  logic [PIX_W-1:0]  rgb565,
  output logic [WORD_W-1:0] rgb444
);

  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;
  logic [3:0] r4;
  logic [3:0] g4;
  logic [3:0] b4;

  assign r5 = rgb565[R5_HI:R5_LO];
  assign g6 = rgb565[G6_HI:G6_LO];
  assign b5 = rgb565[B5_HI:B5_LO];

`ifdef FRAME_WRITER_ROUND_EN
  logic [5:0] r_sum;
  logic [6:0] g_sum;
  logic [5:0] b_sum;

  // Sums can reach 16 after the shift; clamp back into 4 bits.
  assign r_sum = {1'b0, r5} + 6'd1;
  assign g_sum = {1'b0, g6} + 7'd2;
  assign b_sum = {1'b0, b5} + 6'd1;

  assign r4 = r_sum[5] ? 4'hF : r_sum[4:1];
  assign g4 = g_sum[6] ? 4'hF : g_sum[5:2];
  assign b4 = b_sum[5] ? 4'hF : b_sum[4:1];
`else
  logic unused_lsbs;

  assign r4 = r5[4:1];
  assign g4 = g6[5:2];
  assign b4 = b5[4:1];
  assign unused_lsbs = ^{r5[0], g6[1:0], b5[0]};
`endif

  always_comb begin
    rgb444 = '0;
    rgb444[R4_HI:R4_LO] = r4;
    rgb444[G4_HI:G4_LO] = g4;
    rgb444[B4_HI:B4_LO] = b4;
  end

endmodule

// File: rtl/frame_writer.sv
// Streams RGB565 pixels into a rectangular window of a 12-bit frame buffer.
// Colour rounding is selected at build time with FRAME_WRITER_ROUND_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a start-of-frame pixel; non-sof pixels are dropped
// ST_WRITE | writing pixels across the latched window, raster order
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int COL_W = 7,
  parameter int ROW_W = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic [15:0]              in_data,
  input  logic [COL_W-1:0]         win_x0,
  input  logic [COL_W-1:0]         win_x1,
  input  logic [ROW_W-1:0]         win_y0,
  input  logic [ROW_W-1:0]         win_y1,
  input  logic                     wr_stall,
  output logic                     we,
  output logic [COL_W+ROW_W-1:0]   waddr,
  output logic [WORD_W-1:0]        wdata,
  output logic                     frame_done,
  output logic                     frame_abort,
  output logic [15:0]              drop_cnt
);

  fw_state_t state_q, state_d;

  logic [COL_W-1:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [ROW_W-1:0] y_q, y_d, y0_q, y0_d, y1_q, y1_d;

  logic [COL_W-1:0] bx0, bx1, px;
  logic [ROW_W-1:0] by0, by1, py;
  logic             accept;
  logic             last;
  logic             we_d;
  logic             done_d;
  logic             abort_d;
  logic             drop_inc;
  logic [WORD_W-1:0] conv;

  assign in_ready = reset & ~wr_stall;
  assign accept   = in_valid & in_ready;

  rgb565_to_444 u_conv (
    .rgb565 (in_data),
    .rgb444 (conv)
  );

  // A sof pixel uses the freshly clamped window inputs and starts at its origin.
  always_comb begin
    bx0 = x0_q;
    bx1 = x1_q;
    by0 = y0_q;
    by1 = y1_q;
    px  = x_q;
    py  = y_q;
    if (in_sof) begin
      bx0 = win_x0;
      bx1 = (win_x1 < win_x0) ? win_x0 : win_x1;
      by0 = win_y0;
      by1 = (win_y1 < win_y0) ? win_y0 : win_y1;
      px  = bx0;
      py  = by0;
    end
    last = (px == bx1) && (py == by1);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    drop_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_sof) begin
            we_d = 1'b1;
            if (last) done_d = 1'b1;
            else      state_d = ST_WRITE;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (accept) begin
          we_d = 1'b1;
          if (in_sof) abort_d = 1'b1;
          if (last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (we_d) begin
      if (in_sof) begin
        x0_d = bx0;
        x1_d = bx1;
        y0_d = by0;
        y1_d = by1;
      end
      if (px == bx1) begin
        x_d = bx0;
        y_d = py + 1'b1;
      end else begin
        x_d = px + 1'b1;
        y_d = py;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      we          <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      we          <= we_d;
      frame_done  <= done_d;
      frame_abort <= abort_d;
      if (we_d) begin
        waddr <= {py, px};
        wdata <= conv;
      end
      if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed, table-driven bench for frame_writer; honours FRAME_WRITER_ROUND_EN
// for the colour expectations that differ between builds.
module tb_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [15:0] in_data;
  logic [6:0]  win_x0, win_x1, win_y0, win_y1;
  logic        wr_stall;
  logic        we;
  logic [13:0] waddr;
  logic [11:0] wdata;
  logic        frame_done;
  logic        frame_abort;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

`ifdef FRAME_WRITER_ROUND_EN
  localparam logic [11:0] W_MIX = 12'h222;
`else
  localparam logic [11:0] W_MIX = 12'h111;
`endif

  always #5 clk = ~clk;

  frame_writer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sof      (in_sof),
    .in_data     (in_data),
    .win_x0      (win_x0),
    .win_x1      (win_x1),
    .win_y0      (win_y0),
    .win_y1      (win_y1),
    .wr_stall    (wr_stall),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .drop_cnt    (drop_cnt)
  );

  typedef struct {
    logic        valid;
    logic        sof;
    logic [15:0] data;
    logic        stall;
    logic [6:0]  x0, x1, y0, y1;
    logic        e_ready;
    logic        e_we;
    logic [13:0] e_waddr;
    logic [11:0] e_wdata;
    logic        e_done;
    logic        e_abort;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t v(logic valid, logic sof, logic [15:0] data, logic stall,
                             logic [6:0] x0, logic [6:0] x1, logic [6:0] y0, logic [6:0] y1,
                             logic e_ready, logic e_we, logic [13:0] e_waddr, logic [11:0] e_wdata,
                             logic e_done, logic e_abort, logic [15:0] e_drop);
    vec_t r;
    r.valid = valid; r.sof = sof; r.data = data; r.stall = stall;
    r.x0 = x0; r.x1 = x1; r.y0 = y0; r.y1 = y1;
    r.e_ready = e_ready; r.e_we = e_we; r.e_waddr = e_waddr; r.e_wdata = e_wdata;
    r.e_done = e_done; r.e_abort = e_abort; r.e_drop = e_drop;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic valid, input logic sof, input logic [15:0] data, input logic stall,
                       input logic [6:0] x0, input logic [6:0] x1, input logic [6:0] y0, input logic [6:0] y1);
    in_valid = valid; in_sof = sof; in_data = data; wr_stall = stall;
    win_x0 = x0; win_x1 = x1; win_y0 = y0; win_y1 = y1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_seen;

    // Window x 10..12 y 5..6, IDLE drops, stall, then an aborted frame and single-pixel window.
    vecs[0]  = v(1,0,16'h1234,0, 1,2,3,4,   1,0,14'd0,  12'h000,0,0,16'd1);
    vecs[1]  = v(1,0,16'h1234,0, 1,2,3,4,   1,0,14'd0,  12'h000,0,0,16'd2);
    vecs[2]  = v(1,0,16'h1234,0, 1,2,3,4,   1,0,14'd0,  12'h000,0,0,16'd3);
    vecs[3]  = v(0,0,16'h0000,0, 1,2,3,4,   1,0,14'd0,  12'h000,0,0,16'd3);
    vecs[4]  = v(1,1,16'hFFFF,0, 10,12,5,6, 1,1,14'd650,12'hFFF,0,0,16'd3);
    vecs[5]  = v(1,0,16'h18C3,0, 1,2,3,4,   1,1,14'd651,W_MIX,  0,0,16'd3);
    vecs[6]  = v(1,0,16'hAAAA,1, 1,2,3,4,   0,0,14'd0,  12'h000,0,0,16'd3);
    vecs[7]  = v(1,0,16'hAAAA,1, 1,2,3,4,   0,0,14'd0,  12'h000,0,0,16'd3);
    vecs[8]  = v(1,0,16'hAAAA,1, 1,2,3,4,   0,0,14'd0,  12'h000,0,0,16'd3);
    vecs[9]  = v(1,0,16'hAAAA,1, 1,2,3,4,   0,0,14'd0,  12'h000,0,0,16'd3);
    vecs[10] = v(1,0,16'h0000,0, 1,2,3,4,   1,1,14'd652,12'h000,0,0,16'd3);
    vecs[11] = v(0,0,16'h0000,0, 1,2,3,4,   1,0,14'd0,  12'h000,0,0,16'd3);
    vecs[12] = v(1,0,16'h8410,0, 1,2,3,4,   1,1,14'd778,12'h888,0,0,16'd3);
    vecs[13] = v(1,0,16'hF800,0, 1,2,3,4,   1,1,14'd779,12'hF00,0,0,16'd3);
    vecs[14] = v(1,0,16'h07E0,0, 1,2,3,4,   1,1,14'd780,12'h0F0,1,0,16'd3);
    vecs[15] = v(1,0,16'h5555,0, 1,2,3,4,   1,0,14'd0,  12'h000,0,0,16'd4);
    vecs[16] = v(1,1,16'h0000,0, 0,3,1,2,   1,1,14'd128,12'h000,0,0,16'd4);
    vecs[17] = v(1,0,16'h0000,0, 9,9,9,9,   1,1,14'd129,12'h000,0,0,16'd4);
    vecs[18] = v(1,0,16'h0000,0, 9,9,9,9,   1,1,14'd130,12'h000,0,0,16'd4);
    vecs[19] = v(1,0,16'h0000,0, 9,9,9,9,   1,1,14'd131,12'h000,0,0,16'd4);
    vecs[20] = v(1,0,16'h0000,0, 9,9,9,9,   1,1,14'd256,12'h000,0,0,16'd4);
    vecs[21] = v(1,1,16'h0000,0, 20,21,3,1, 1,1,14'd404,12'h000,0,1,16'd4);
    vecs[22] = v(1,0,16'h0000,0, 0,0,0,0,   1,1,14'd405,12'h000,1,0,16'd4);
    vecs[23] = v(1,1,16'h0000,0, 7,3,2,0,   1,1,14'd263,12'h000,1,0,16'd4);
    vecs[24] = v(1,0,16'h0000,0, 7,3,2,0,   1,0,14'd0,  12'h000,0,0,16'd5);

    // Reset state
    reset = 1'b0;
    drive(0,0,16'h0,0, 0,0,0,0);
    step();
    step();
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", {18'd0, waddr}, 32'd0);
    chk("rst_wdata", {20'd0, wdata}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_abort", {31'd0, frame_abort}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].valid, vecs[i].sof, vecs[i].data, vecs[i].stall,
            vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ready});
      step();
      chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_done", i), {31'd0, frame_done}, {31'd0, vecs[i].e_done});
      chk($sformatf("v%0d_abort", i), {31'd0, frame_abort}, {31'd0, vecs[i].e_abort});
      chk($sformatf("v%0d_drop", i), {16'd0, drop_cnt}, {16'd0, vecs[i].e_drop});
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_waddr", i), {18'd0, waddr}, {18'd0, vecs[i].e_waddr});
        chk($sformatf("v%0d_wdata", i), {20'd0, wdata}, {20'd0, vecs[i].e_wdata});
      end
    end

    // Reset mid-frame: outputs clear on the next edge, no done/abort, back in IDLE.
    drive(1,1,16'hFFFF,0, 0,3,0,1);
    step();
    chk("mr_first_waddr", {18'd0, waddr}, 32'd0);
    drive(1,0,16'hFFFF,0, 0,0,0,0);
    step();
    chk("mr_second_waddr", {18'd0, waddr}, 32'd1);
    chk("mr_second_wdata", {20'd0, wdata}, 32'hFFF);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_ready_in_reset", {31'd0, in_ready}, 32'd0);
    step();
    chk("mr_we", {31'd0, we}, 32'd0);
    chk("mr_waddr", {18'd0, waddr}, 32'd0);
    chk("mr_wdata", {20'd0, wdata}, 32'd0);
    chk("mr_done", {31'd0, frame_done}, 32'd0);
    chk("mr_abort", {31'd0, frame_abort}, 32'd0);
    chk("mr_drop", {16'd0, drop_cnt}, 32'd0);
    reset = 1'b1;
    step();
    chk("mr_idle_we", {31'd0, we}, 32'd0);
    chk("mr_idle_drop", {16'd0, drop_cnt}, 32'd1);
    chk("mr_idle_done", {31'd0, frame_done}, 32'd0);
    chk("mr_idle_abort", {31'd0, frame_abort}, 32'd0);

    // Full 128x128 window in raster order.
    done_seen = 0;
    for (int i = 0; i < 16384; i++) begin
      drive(1, (i == 0), i[15:0], 0, 0, 127, 0, 127);
      step();
      if (frame_done) done_seen++;
      if (we !== 1'b1 || waddr !== i[13:0]) begin
        chk($sformatf("full_w%0d_waddr", i), {17'd0, we, waddr}, {17'd0, 1'b1, i[13:0]});
      end else begin
        checks++;
      end
    end
    chk("full_done_last", {31'd0, frame_done}, 32'd1);
    chk("full_done_count", done_seen, 32'd1);
    drive(0,0,16'h0,0, 0,0,0,0);
    step();
    chk("full_after_we", {31'd0, we}, 32'd0);
    chk("full_after_done", {31'd0, frame_done}, 32'd0);
    chk("full_drop_unchanged", {16'd0, drop_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
